// File: rtl/zigzag_pkg.sv
// Shared types and defaults for the zig-zag reorder stage.
// The quant/RLE stages take their default coefficient width and block size from here.
package zigzag_pkg;

  localparam int unsigned ZZ_W = 11;
  localparam int unsigned ZZ_N = 8;

  typedef enum logic {
    UP_RIGHT  = 1'b0,
    DOWN_LEFT = 1'b1
  } dir_e;

  // Raster index (row*n+col) of zig-zag position k in an n x n block.
  // This is a behavioural model for simulation, not a hardware path.
  function automatic int unsigned zz_raster(input int unsigned k, input int unsigned n);
    int unsigned r;
    int unsigned c;
    dir_e        d;
    r = 0;
    c = 0;
    d = UP_RIGHT;
    for (int unsigned i = 0; i < k; i++) begin
      if (d == UP_RIGHT) begin
        if (c == n - 1) begin
          r++;
          d = DOWN_LEFT;
        end else if (r == 0) begin
          c++;
          d = DOWN_LEFT;
        end else begin
          r--;
          c++;
        end
      end else begin
        if (r == n - 1) begin
          c++;
          d = UP_RIGHT;
        end else if (c == 0) begin
          r++;
          d = UP_RIGHT;
        end else begin
          r++;
          c--;
        end
      end
    end
    return r * n + c;
  endfunction

endpackage

// File: rtl/zigzag_walker.sv
// Zig-zag position generator: holds row/col/direction and steps one position per adv.
// restart returns to (0,0) heading up-right and takes priority over adv.
module zigzag_walker
  import zigzag_pkg::*;
#(
  parameter int unsigned N = ZZ_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 restart,
  output logic [$clog2(N)-1:0] row,
  output logic [$clog2(N)-1:0] col
);

  localparam int unsigned RW = $clog2(N);
  localparam logic [RW-1:0] Edge = RW'(N - 1);

  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  dir_e          dir_q, dir_d;

  // Next position along the zig-zag path.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    dir_d = dir_q;
    unique case (dir_q)
      UP_RIGHT: begin
        if (col_q == Edge) begin
          row_d = row_q + RW'(1);
          dir_d = DOWN_LEFT;
        end else if (row_q == '0) begin
          col_d = col_q + RW'(1);
          dir_d = DOWN_LEFT;
        end else begin
          row_d = row_q - RW'(1);
          col_d = col_q + RW'(1);
        end
      end
      DOWN_LEFT: begin
        if (row_q == Edge) begin
          col_d = col_q + RW'(1);
          dir_d = UP_RIGHT;
        end else if (col_q == '0) begin
          row_d = row_q + RW'(1);
          dir_d = UP_RIGHT;
        end else begin
          row_d = row_q + RW'(1);
          col_d = col_q - RW'(1);
        end
      end
      default: ;
    endcase
  end

  // Position register; restart wins over a simultaneous advance.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      row_q <= '0;
      col_q <= '0;
      dir_q <= UP_RIGHT;
    end else if (adv) begin
      row_q <= row_d;
      col_q <= col_d;
      dir_q <= dir_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/zigzag_stream.sv
// Streaming NxN zig-zag reorder with ping-pong banks, one coefficient per cycle each side.
// Optional ZIGZAG_INVERSE_EN adds a per-block mode input selecting inverse (de-zigzag) blocks.
module zigzag_stream
  import zigzag_pkg::*;
#(
  parameter int unsigned W  = ZZ_W,
  parameter int unsigned N  = ZZ_N,
  parameter int unsigned AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef ZIGZAG_INVERSE_EN
  input  logic          mode,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last
);

  localparam int unsigned NN = N * N;
  localparam int unsigned RW = $clog2(N);
  localparam logic [AW-1:0] Last = AW'(NN - 1);

  logic [W-1:0]  bank_q [2][NN];
  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, rd_sel_q;
  logic [AW-1:0] wr_cnt_q, rd_cnt_q;
  logic          wr_fire, rd_fire, wr_done, rd_done;
  logic [AW-1:0] waddr, raddr;
  logic [RW-1:0] rd_row, rd_col;

  assign in_ready  = !full_q[wr_sel_q] && !rst;
  assign out_valid = full_q[rd_sel_q] && !rst;
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_done   = wr_fire && (wr_cnt_q == Last);
  assign rd_done   = rd_fire && (rd_cnt_q == Last);

  zigzag_walker #(
    .N (N)
  ) u_rd_walker (
    .clk     (clk),
    .rst     (rst),
    .adv     (rd_fire),
    .restart (rd_done),
    .row     (rd_row),
    .col     (rd_col)
  );

`ifdef ZIGZAG_INVERSE_EN
  logic [RW-1:0] wr_row, wr_col;
  logic [1:0]    mode_q;

  zigzag_walker #(
    .N (N)
  ) u_wr_walker (
    .clk     (clk),
    .rst     (rst),
    .adv     (wr_fire),
    .restart (wr_done),
    .row     (wr_row),
    .col     (wr_col)
  );

  // Block mode is latched per bank on its first coefficient; both address
  // sources are 0 at that point, so the stale mode_q for that beat is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
    end else if (wr_fire && (wr_cnt_q == '0)) begin
      mode_q[wr_sel_q] <= mode;
    end
  end

  assign waddr = mode_q[wr_sel_q] ? {wr_row, wr_col} : wr_cnt_q;
  assign raddr = mode_q[rd_sel_q] ? rd_cnt_q : {rd_row, rd_col};
`else
  assign waddr = wr_cnt_q;
  assign raddr = {rd_row, rd_col};
`endif

  // Bank occupancy: write side may set one bank while the read side clears the other.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_sel_q] = 1'b1;
    if (rd_done) full_d[rd_sel_q] = 1'b0;
  end

  // Control state: bank selects and beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      full_q <= full_d;
      if (wr_fire) begin
        wr_cnt_q <= wr_done ? '0 : wr_cnt_q + AW'(1);
        if (wr_done) wr_sel_q <= !wr_sel_q;
      end
      if (rd_fire) begin
        rd_cnt_q <= rd_done ? '0 : rd_cnt_q + AW'(1);
        if (rd_done) rd_sel_q <= !rd_sel_q;
      end
    end
  end

  // Coefficient storage, deliberately not reset; in_ready gates writes during rst.
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_sel_q][waddr] <= in_data;
  end

  assign out_data = out_valid ? bank_q[rd_sel_q][raddr] : '0;
  assign out_idx  = out_valid ? rd_cnt_q : '0;
  assign out_last = out_valid && (rd_cnt_q == Last);

endmodule

// File: tb/tb_zigzag_stream.sv
// Self-checking bench for zigzag_stream (N=8/W=11 main instance, N=4/W=8 side instance).
// Build with ZIGZAG_INVERSE_EN defined to also cover inverse blocks.
module tb_zigzag_stream;
  import zigzag_pkg::*;

  typedef struct packed {
    logic [10:0] d;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [10:0] in_data, out_data;
  logic [5:0]  out_idx;

  logic        mode4;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
  logic [7:0]  in_data4, out_data4;
  logic [3:0]  out_idx4;

  exp_t        exp_q[$];
  int          in_q[$];
  bit          inm_q[$];
  int          blk_buf[$];
  int          got_q[$];
  bit          blk_mode;
  int          vecs = 0;
  int          errs = 0;
  bit          rnd_ready = 1'b0;
  bit          chk_rdy = 1'b0;
  bit          hold_v = 1'b0;
  logic [10:0] hold_d;
  logic [5:0]  hold_i;
  logic        hold_l;

  always #5 clk = ~clk;

  zigzag_stream #(
    .W (11),
    .N (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ZIGZAG_INVERSE_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  zigzag_stream #(
    .W (8),
    .N (4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
`ifdef ZIGZAG_INVERSE_EN
    .mode      (mode4),
`endif
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .out_idx   (out_idx4),
    .out_last  (out_last4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Queue the expected output beats for the block just completed in blk_buf.
  task automatic push_block();
    int   arr[64];
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      if (blk_mode) arr[zz_raster(k, 8)] = blk_buf[k];
      else          arr[k] = blk_buf[zz_raster(k, 8)];
    end
    for (int k = 0; k < 64; k++) begin
      e.d    = 11'(arr[k]);
      e.idx  = 6'(k);
      e.last = (k == 63);
      exp_q.push_back(e);
    end
  endtask

  // One clock of the main instance: drive at #1 after posedge, check at negedge.
  task automatic step();
    exp_t e;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    in_valid = (in_q.size() > 0);
    in_data  = in_valid ? 11'(in_q[0]) : '0;
    mode     = in_valid ? inm_q[0] : 1'b0;
    @(negedge clk);
    if (hold_v) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, hold_d);
      check("stall_idx", out_idx, hold_i);
      check("stall_last", out_last, hold_l);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_i = out_idx;
    hold_l = out_last;
    if (out_valid && out_ready) begin
      got_q.push_back(int'(out_data));
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.d);
        check("out_idx", out_idx, e.idx);
        check("out_last", out_last, e.last);
      end
    end
    if (chk_rdy && in_valid) check("in_ready_steady", in_ready, 1);
    if (in_valid && in_ready) begin
      if (blk_buf.size() == 0) blk_mode = inm_q[0];
      blk_buf.push_back(in_q.pop_front());
      void'(inm_q.pop_front());
      if (blk_buf.size() == 64) begin
        push_block();
        blk_buf.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check("drain_done", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic push_ramp(input int base, input int count, input bit m);
    for (int i = 0; i < count; i++) begin
      in_q.push_back(base + i);
      inm_q.push_back(m);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ref8[10];
    int ref4[16];
    int n;
    int k;
    ref8 = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    ref4 = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    rst = 1'b1;
    mode = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    mode4 = 1'b0;
    in_valid4 = 1'b0;
    in_data4 = '0;
    out_ready4 = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single ramp block, latency and reference order.
    push_ramp(0, 64, 1'b0);
    n = 0;
    while (in_q.size() > 0 && n < 200) begin
      check("no_early_valid", out_valid, 0);
      step();
      n++;
    end
    check("first_valid_latency", out_valid, 1);
    check("first_out_data", out_data, 0);
    drain(500);
    check("ramp_beats", got_q.size(), 64);
    for (int i = 0; i < 10; i++) begin
      if (i < got_q.size()) check("zz8_ref", got_q[i], ref8[i]);
    end
    if (got_q.size() == 64) check("zz8_final", got_q[63], 63);

    // Three back-to-back blocks: in_ready stays high, outputs contiguous.
    got_q.delete();
    chk_rdy = 1'b1;
    push_ramp(0, 192, 1'b0);
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < 1000) begin
      step();
      n++;
    end
    chk_rdy = 1'b0;
    check("b2b_cycles", n, 256);
    check("b2b_beats", got_q.size(), 192);

    // Back-pressure: both banks fill, then random stalls drain everything.
    out_ready = 1'b0;
    push_ramp(500, 192, 1'b0);
    repeat (140) step();
    check("bp_accepts", 192 - in_q.size(), 128);
    check("bp_in_ready", in_ready, 0);
    rnd_ready = 1'b1;
    drain(3000);
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a block discards it.
    push_ramp(1000, 64, 1'b0);
    repeat (30) step();
    in_q.delete();
    inm_q.delete();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    blk_buf.delete();
    hold_v = 1'b0;
    @(posedge clk);
    #1;
    repeat (5) begin
      step();
      check("no_stale_valid", out_valid, 0);
    end
    got_q.delete();
    push_ramp(0, 64, 1'b0);
    drain(500);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("post_rst_order", got_q[i], ref8[i]);
    end

`ifdef ZIGZAG_INVERSE_EN
    // Forward block followed by inverse block fed with the forward order.
    got_q.delete();
    push_ramp(0, 64, 1'b0);
    for (int i = 0; i < 64; i++) begin
      in_q.push_back(int'(zz_raster(i, 8)));
      inm_q.push_back(1'b1);
    end
    drain(1000);
    check("inv_beats", got_q.size(), 128);
    for (int i = 0; i < 64; i++) begin
      if (64 + i < got_q.size()) check("inv_raster", got_q[64 + i], i);
    end
`endif

    // N=4 instance.
    for (int i = 0; i < 16; i++) begin
      in_valid4 = 1'b1;
      in_data4 = 8'(i);
      @(negedge clk);
      check("n4_in_ready", in_ready4, 1);
      @(posedge clk);
      #1;
    end
    in_valid4 = 1'b0;
    k = 0;
    n = 0;
    while (k < 16 && n < 100) begin
      @(negedge clk);
      if (out_valid4) begin
        check("n4_data", out_data4, ref4[k]);
        check("n4_idx", out_idx4, k);
        check("n4_last", out_last4, (k == 15));
        k++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("n4_count", k, 16);
    check("n4_idle", out_valid4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/zigzag_stream.md
Name: zigzag_stream

Overview:
- Streaming, parametrised zig-zag reorder for the JPEG-style coefficient path.
- Accepts one NxN coefficient block in raster order over a valid/ready interface.
- Emits the block in zig-zag order over a second valid/ready interface.
- Ping-pong buffering sustains one coefficient per cycle, replacing the all-parallel 8x8 combinational reorder.

Parameters:
- W, 11: coefficient width in bits.
- N, 8: block dimension. Power of two, N >= 2. Block holds N*N coefficients.
- AW, $clog2(N*N): derived index width. Not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  W  coefficient, raster order (row-major, row = first index).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  coefficient in zig-zag order.
- out_idx  out  AW  zig-zag position 0..N*N-1 of out_data.
- out_last  out  1  high with out_idx == N*N-1.

Behaviour:
- Storage: two banks of N*N x W flops (bank0, bank1). Storage is not reset.
- State: full[1:0], wr_sel, rd_sel, wr_cnt (AW), rd_cnt (AW), and walker row/col/dir.
- Reset: full=0, wr_sel=rd_sel=0, counts=0, walker at (0,0) moving up-right.
- Outputs while rst is high and the cycle after: in_ready=0 during rst; out_valid=0, out_data=0, out_idx=0, out_last=0.
- Write side:
  - in_ready = !full[wr_sel] && !rst.
  - On in_valid && in_ready: bank[wr_sel][wr_cnt] <= in_data; wr_cnt++.
  - When wr_cnt == N*N-1 on accept: full[wr_sel] <= 1, wr_sel toggles, wr_cnt wraps to 0.
- Read side:
  - out_valid = full[rd_sel].
  - out_data = bank[rd_sel][row*N+col], masked to 0 when !out_valid. out_idx = rd_cnt.
  - On out_valid && out_ready: walker advances, rd_cnt++.
  - At rd_cnt == N*N-1: full[rd_sel] <= 0, rd_sel toggles, walker returns to (0,0) up-right.
- Walker step rules:
  - Up-right: if col==N-1 then row+1, go down-left; elif row==0 then col+1, go down-left; else row-1, col+1.
  - Down-left: if row==N-1 then col+1, go up-right; elif col==0 then row+1, go up-right; else row+1, col-1.
- Latency: first zig-zag output is valid the cycle after the block's final input is accepted.
- Throughput: sustained 1/cycle on both sides with out_ready=1. in_ready never drops in steady state.
- Stall: out_data, out_idx and out_last hold stable while out_valid && !out_ready. An AXI-style valid never retracts.
- Simultaneous events:
  - A write-side set of full[x] and a read-side clear of full[y] in the same cycle both take effect; x != y always.
  - The bank being drained is never written.
- Both full: in_ready=0 until the current read bank finishes draining.
- Reset mid-block: the partial block is discarded and no output follows. The first post-reset input is raster index 0.

Optional Feature:
- Macro: ZIGZAG_INVERSE_EN.
- Defined:
  - Adds port `mode in 1` (0 = forward zig-zag, 1 = inverse/de-zigzag).
  - mode is sampled on the first accepted coefficient of each block and stored per bank.
  - Inverse banks: writes use a second walker instance for the address and input arrives in zig-zag order; reads are sequential raster. out_idx then gives the raster position.
  - Forward and inverse blocks may alternate back to back.
- Undefined: no mode port; forward only; one walker instance.

Decomposition:
- Package zigzag_pkg:
  - dir_e enum (UP_RIGHT, DOWN_LEFT).
  - Function zz_raster(k, N), used by the bench as the reference model.
  - Default W/N localparams shared with the quant/RLE stages.
- Sub-module zigzag_walker (params N; ports clk, rst, adv, restart, row, col).
  - Holds row/col/dir and implements the step rules.
  - Instantiated once, or twice under ZIGZAG_INVERSE_EN.

Test Plan:
- N=8, W=11, ramp in_data=0..63, out_ready=1 -> out_data sequence 0,1,8,16,9,2,3,10,17,24,... ending 63. out_last only on the 64th output. First out_valid the cycle after the 64th input.
- Three back-to-back ramp blocks (offsets 0, 64, 128), out_ready=1 -> in_ready stays 1 throughout. Outputs contiguous, 192 beats, each block correctly ordered.
- out_ready=0 with in_valid=1 -> in_ready falls after exactly 128 accepts. Random out_ready toggling then yields stable data during stalls and no loss or duplication.
- Reset asserted after 30 inputs of a block -> out_valid=0. A following full ramp block outputs 0,1,8,16,... with no stale data.
- N=4, W=8, ramp 0..15 -> output 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15.
- ZIGZAG_INVERSE_EN: forward block followed by inverse block fed with the forward output -> inverse output equals the original raster ramp 0..63.
